// File: rtl/pc_unit.sv
// pc_unit: program counter and next-PC selection (PC+4, BEQ/BNE, J/JAL, JR) with stall hold,
//          misaligned-target trap with sticky fault capture, and retired-instruction counter.
// Latency: next-PC is combinational from the inputs; pc_o updates at the next rising edge.
// Backpressure: stall_i freezes PC, counter, fault state and return stack. Optional stack: PC_RAS_EN.
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0180),
    parameter int                CNT_W     = 32,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              branch_ne_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] imm_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_target_i,
    input  logic              link_i,
    input  logic              jump_reg_i,
    input  logic              ret_i,
    input  logic [ADDR_W-1:0] reg_target_i,
    input  logic              fault_clr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fault_o,
    output logic [ADDR_W-1:0] fault_pc_o,
    output logic [CNT_W-1:0]  retired_o,
    output logic              ras_empty_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  retired_q;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              br_taken;
    logic [ADDR_W-1:0] tgt_sel;
    logic              tgt_chk;
    logic              fault_now;

    logic              ras_pop;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;

    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign br_tgt   = pc_plus4 + {imm_i[ADDR_W-3:0], 2'b00};
    assign jmp_tgt  = {pc_plus4[ADDR_W-1:28], jump_target_i, 2'b00};
    assign br_taken = branch_i & (zero_i ^ branch_ne_i);

`ifdef PC_RAS_EN
    localparam int PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int OCC_W  = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wp_q;
    logic [PTR_W-1:0]  wp_inc;
    logic [PTR_W-1:0]  wp_dec;
    logic [OCC_W-1:0]  occ_q;
    logic              ras_push;

    // wp_q is the next free slot; the top of stack sits one below it (circular)
    assign wp_inc    = (wp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
    assign wp_dec    = (wp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : wp_q - PTR_W'(1);
    assign ras_empty = (occ_q == '0);
    assign ras_top   = ras_q[wp_dec];
    assign ras_pop   = ret_i & ~ras_empty;
    // a return outranks a call, so a simultaneous push is dropped
    assign ras_push  = jump_i & link_i & ~fault_now & ~ras_pop;

    // Return stack: push overwrites the oldest entry when full, occupancy saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (!stall_i) begin
            if (ras_pop) begin
                wp_q  <= wp_dec;
                occ_q <= occ_q - OCC_W'(1);
            end else if (ras_push) begin
                ras_q[wp_q] <= pc_plus4;
                wp_q        <= wp_inc;
                if (occ_q != OCC_W'(RAS_DEPTH)) begin
                    occ_q <= occ_q + OCC_W'(1);
                end
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = link_i ^ (RAS_DEPTH > 0);
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign ras_pop    = 1'b0;
`endif

    // Next-PC priority; only register/stack targets can be misaligned
    always_comb begin
        tgt_sel = pc_plus4;
        tgt_chk = 1'b0;
        if (ras_pop) begin
            tgt_sel = ras_top;
            tgt_chk = 1'b1;
        end else if (jump_reg_i || ret_i) begin
            tgt_sel = reg_target_i;
            tgt_chk = 1'b1;
        end else if (jump_i) begin
            tgt_sel = jmp_tgt;
        end else if (br_taken) begin
            tgt_sel = br_tgt;
        end
        fault_now = tgt_chk & (tgt_sel[1:0] != 2'b00);
        pc_d      = fault_now ? TRAP_VEC : tgt_sel;
    end

    // Sticky fault: a new fault beats a same-cycle clear; the address is kept from the first fault
    always_comb begin
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (fault_now) begin
            fault_d = 1'b1;
            if (!fault_q || fault_clr_i) begin
                fault_pc_d = tgt_sel;
            end
        end else if (fault_clr_i) begin
            fault_d = 1'b0;
        end
    end

    // PC, fault and retired counter registers; all frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            retired_q  <= '0;
        end else if (!stall_i) begin
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            retired_q  <= retired_q + CNT_W'(1);
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4;
    assign fault_o     = fault_q;
    assign fault_pc_o  = fault_pc_q;
    assign retired_o   = retired_q;
    assign ras_empty_o = ras_empty;

endmodule
